// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types, constants and width helpers for the
//                instruction-fetch prefetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Native datapath width of the default configuration.
    localparam int unsigned FETCH_NBITS = 32;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_INC = 4;

    // One prefetched instruction as seen by decode.
    typedef struct packed {
        logic [FETCH_NBITS-1:0] pc;
        logic [FETCH_NBITS-1:0] instr;
    } fetch_entry_t;

    // Word-index width of an instruction memory with 'words' entries.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Width able to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : DEPTH-entry synchronous FIFO with flush. The head is read
//                straight from registered storage, so a push into an empty
//                queue becomes visible on the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = level_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [LW-1:0]    o_level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [LW-1:0]    count_q;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Guard push/pop against full/empty so pointers never overrun.
    always_comb begin
        w_push_ok = i_push & (count_q != LW'(DEPTH));
        w_pop_ok  = i_pop  & (count_q != '0);
    end

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else if (i_flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (w_push_ok) begin
                slot_q[wr_q] <= i_data;
                wr_q         <= wr_q + AW'(1);
            end
            if (w_pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: ;
            endcase
        end
    end

    assign o_valid = (count_q != '0);
    assign o_data  = slot_q[rd_q];
    assign o_level = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_unit
//  Description : Instruction-fetch stage: PC register, debug-writable
//                synchronous instruction memory, prefetch queue feeding
//                decode over valid/ready, flush-and-redirect, run/step
//                enable and cycle/stall statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     NBITS     = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MEM_WORDS = 256,
    parameter logic [NBITS-1:0] RESET_PC = '0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic                            i_redirect,
    input  logic [NBITS-1:0]                i_redirect_pc,
    input  logic                            i_ready,
    output logic                            o_valid,
    output logic [NBITS-1:0]                o_pc,
    output logic [NBITS-1:0]                o_instr,
    output logic [$clog2(DEPTH+1)-1:0]      o_level,
    input  logic                            i_dbg_wr_en,
    input  logic [NBITS-1:0]                i_dbg_addr,
    input  logic [NBITS-1:0]                i_dbg_data,
    output logic [NBITS-1:0]                o_dbg_data,
    output logic [NBITS-1:0]                o_cycle_count,
    output logic [NBITS-1:0]                o_stall_count
);

    localparam int unsigned IW = idx_width(MEM_WORDS);
    localparam int unsigned LW = level_width(DEPTH);
    localparam int unsigned DW = LW + 1;
    localparam int unsigned EW = 2 * NBITS;

    logic [NBITS-1:0] mem_q [MEM_WORDS];
    logic [NBITS-1:0] fpc_q, fpc_d;
    logic             inflight_q, inflight_d;
    logic [NBITS-1:0] cycle_q, cycle_d;
    logic [NBITS-1:0] stall_q, stall_d;
    logic [NBITS-1:0] resp_pc_q;
    logic [NBITS-1:0] resp_instr_q;
    logic [NBITS-1:0] dbg_data_q;

    logic [IW-1:0]    w_fetch_idx;
    logic [IW-1:0]    w_dbg_idx;
    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic             w_issue;
    logic [DW-1:0]    w_demand;
    logic             w_q_valid;
    logic [EW-1:0]    w_head;
    logic [LW-1:0]    w_level;
    logic             w_unused_addr_bits;

    // Word index ignores the byte offset; upper address bits alias.
    assign w_fetch_idx        = fpc_q[IW+1:2];
    assign w_dbg_idx          = i_dbg_addr[IW+1:2];
    assign w_unused_addr_bits = ^{i_dbg_addr[NBITS-1:IW+2], i_dbg_addr[1:0]};

    // Per-cycle handshake decisions. Issue budget counts the queued entries
    // plus the one in flight, minus the slot freed by a pop this cycle.
    always_comb begin
        w_pop    = i_en & w_q_valid & i_ready;
        w_flush  = i_en & i_redirect;
        w_push   = i_en & ~i_redirect & inflight_q;
        w_demand = DW'(w_level) + DW'(inflight_q) - DW'(w_pop);
        w_issue  = i_en & ~i_redirect & (w_demand < DW'(DEPTH));
    end

    // Next fetch PC, in-flight flag and statistics; all frozen while i_en=0.
    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = inflight_q;
        cycle_d    = cycle_q;
        stall_d    = stall_q;
        if (i_en) begin
            cycle_d    = cycle_q + NBITS'(1);
            inflight_d = w_issue;
            if (w_q_valid && !i_ready) begin
                stall_d = stall_q + NBITS'(1);
            end
            if (i_redirect) begin
                fpc_d = i_redirect_pc;
            end else if (w_issue) begin
                fpc_d = fpc_q + NBITS'(PC_INC);
            end
        end
    end

    // Fetch state and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fpc_q      <= RESET_PC;
            inflight_q <= 1'b0;
            cycle_q    <= '0;
            stall_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
        end
    end

    // Debug write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_dbg_wr_en) begin
            mem_q[w_dbg_idx] <= i_dbg_data;
        end
    end

    // Synchronous fetch and debug reads; both see pre-write data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            resp_pc_q    <= '0;
            resp_instr_q <= '0;
            dbg_data_q   <= '0;
        end else begin
            dbg_data_q <= mem_q[w_dbg_idx];
            if (w_issue) begin
                resp_pc_q    <= fpc_q;
                resp_instr_q <= mem_q[w_fetch_idx];
            end
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  ({resp_pc_q, resp_instr_q}),
        .i_pop   (w_pop),
        .o_valid (w_q_valid),
        .o_data  (w_head),
        .o_level (w_level)
    );

    assign o_valid       = w_q_valid;
    assign o_pc          = w_head[EW-1:NBITS];
    assign o_instr       = w_head[NBITS-1:0];
    assign o_level       = w_level;
    assign o_dbg_data    = dbg_data_q;
    assign o_cycle_count = cycle_q;
    assign o_stall_count = stall_q;

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch stage that decouples PC generation from decode. It holds a PC register, a debug-writable synchronous instruction memory and a DEPTH-entry prefetch queue, and presents each fetched {pc, instr} pair to decode over a valid/ready handshake. It supports flush-and-redirect for jumps and branches, a global run/step enable, and cycle/stall statistics. It sits between the debug unit (memory load, stepping) and the decode stage.

## Interface
- NBITS, 32, data/address width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- MEM_WORDS, 256, instruction memory words; power of two
- RESET_PC, 0, PC after reset; word aligned
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  run/step enable; at 0, all fetch state, queue and counters freeze
- i_redirect  in  1  flush and redirect; honoured only when i_en=1
- i_redirect_pc  in  NBITS  redirect target
- i_ready  in  1  decode accepts the head entry; 0 = hazard stall
- o_valid  out  1  head entry is valid
- o_pc  out  NBITS  PC of the head entry
- o_instr  out  NBITS  instruction of the head entry
- o_level  out  $clog2(DEPTH+1)  queue occupancy
- i_dbg_wr_en  in  1  debug memory write strobe; works regardless of i_en
- i_dbg_addr  in  NBITS  debug byte address
- i_dbg_data  in  NBITS  debug write data
- o_dbg_data  out  NBITS  registered read of i_dbg_addr
- o_cycle_count  out  NBITS  count of cycles with i_en=1
- o_stall_count  out  NBITS  count of cycles with i_en & o_valid & ~i_ready

## Operation
- Memory index is addr[$clog2(MEM_WORDS)+1:2]. Bits [1:0] are ignored. Higher bits alias, so the index wraps modulo MEM_WORDS.
- Pop occurs when i_en & o_valid & i_ready.
- Issue occurs when i_en & ~i_redirect & (level + inflight − pop < DEPTH). On issue, the memory reads fpc, the response registers with its PC, and fpc advances by 4 (wraps mod 2^NBITS). inflight is 0 or 1.
- A response is pushed into the queue one cycle after its issue, unless a redirect is asserted in that cycle, in which case it is discarded.
- Redirect (i_en=1): the queue and in-flight response are cleared and fpc <= i_redirect_pc. A pop in the same cycle still completes. No issue happens in the redirect cycle.
- Debug write and a fetch to the same word in the same cycle: the fetch returns the old data (read-before-write).
- o_dbg_data returns the word at i_dbg_addr one cycle later. It also uses read-before-write.
- Both counters wrap at 2^NBITS.
- Reset (at any time, including mid-fetch): fpc=RESET_PC, queue empty, inflight=0, o_valid=0, o_level=0, o_pc=0, o_instr=0, o_dbg_data=0, both counters 0. Memory contents are preserved.

## Timing
- Cycle 0 is the first cycle with i_rst=0 and i_en=1. The read of RESET_PC issues in cycle 0 and the entry is pushed at the end of cycle 1, so o_valid=1 in cycle 2.
- Steady state: one entry per cycle with i_ready held high, for any DEPTH≥2.
- Redirect in cycle k: o_valid=0 in k+1 and the target entry is valid in k+3. Redirects in consecutive cycles keep only the last target.
- Full queue: no issue occurs. Issue resumes in the same cycle as a pop.
- Empty queue with a push: the entry is visible on the next cycle. There is no combinational fall-through.
- i_en=0: outputs hold their values and the counters do not advance.

## Structure
- Package fetch_pkg holds: the entry struct {pc, instr}, the PC increment constant 4, and the index-width and level-width localparam functions.
- One sub-module, fetch_queue: a DEPTH-entry synchronous FIFO with a flush input, push/pop, and level output.
- Memory, PC register, issue logic and counters live in the top block.

## Test plan
- Memory preloaded with word i = 0x1000+i, i_ready=1 after reset -> o_valid first in cycle 2 with o_pc=0, o_instr=0x1000; then 0x4/0x1001 and 0x8/0x1002 on consecutive cycles.
- i_ready=0 for 10 cycles with DEPTH=4 -> o_level settles at 4, o_pc holds, o_stall_count +10; on release, 4 back-to-back pops are followed by gapless flow.
- Redirect to 0x40 in cycle 5 with a pop in the same cycle -> pop completes, o_valid=0 in cycle 6, cycle 8 shows o_pc=0x40, o_instr=0x1010.
- Debug write 0xDEAD to 0x8 in the same cycle as a fetch of 0x8 -> the entry carries the old 0x1002; a refetch after a redirect to 0x8 carries 0xDEAD; o_dbg_data reads 0xDEAD.
- i_en toggling 1,0,1,0 -> fetch and counters advance only in enabled cycles; o_cycle_count=2 after 4 cycles.
- Reset asserted with the queue full and inflight=1 -> next cycle all outputs are 0, and the restart fetches RESET_PC with no stale entry.
